// File: rtl/tlb_maint_pkg.sv
// Shared types, constants and op-decode helpers for the TLB maintenance controller.
package tlb_maint_pkg;

  typedef enum logic [2:0] {
    TlbOpSrch = 3'd0,
    TlbOpRd   = 3'd1,
    TlbOpWr   = 3'd2,
    TlbOpFill = 3'd3,
    TlbOpInv  = 3'd4
  } TlbOpE;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWait,
    StSettle,
    StResp
  } TlbMaintStateE;

  localparam logic [4:0]  INVTLB_OP_MAX = 5'd6;
  localparam logic [15:0] LFSR_SEED     = 16'hACE1;

  // Bit positions of the MMU enable vector.
  localparam int unsigned EnSrch = 0;
  localparam int unsigned EnRd   = 1;
  localparam int unsigned EnWr   = 2;
  localparam int unsigned EnFill = 3;
  localparam int unsigned EnInv  = 4;

  typedef struct packed {
    TlbOpE       op;
    logic [4:0]  inv_op;
    logic [9:0]  asid;
    logic [18:0] vpn;
  } TlbMaintReqSt;

  typedef struct packed {
    logic valid;
    logic found;
    logic ine;
  } TlbMaintRspSt;

  function automatic logic is_illegal_inv(TlbMaintReqSt req);
    return (req.op == TlbOpInv) && (req.inv_op > INVTLB_OP_MAX);
  endfunction

  function automatic logic [4:0] op_enable_mask(TlbMaintReqSt req);
    logic [4:0] mask;
    mask = '0;
    case (req.op)
      TlbOpSrch: mask[EnSrch] = 1'b1;
      TlbOpRd:   mask[EnRd]   = 1'b1;
      TlbOpWr:   mask[EnWr]   = 1'b1;
      TlbOpFill: mask[EnFill] = 1'b1;
      TlbOpInv:  mask[EnInv]  = !is_illegal_inv(req);
      default:   mask = '0;
    endcase
    return mask;
  endfunction

  // Ops that change TLB contents and therefore must stall translation.
  function automatic logic op_blocks(TlbMaintReqSt req);
    return (req.op inside {TlbOpWr, TlbOpFill}) ||
           ((req.op == TlbOpInv) && !is_illegal_inv(req));
  endfunction

endpackage

// File: rtl/tlb_maint_ctrl_if.sv
// Request/response handshake between commit/CSR and the TLB maintenance controller.
interface tlb_maint_ctrl_if #(
  parameter int unsigned TLB_ENTRY_NUM = 32
);
  localparam int unsigned IDX_W = $clog2(TLB_ENTRY_NUM);

  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_op;
  logic [4:0]       req_inv_op;
  logic [9:0]       req_asid;
  logic [18:0]      req_vpn;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_found;
  logic [IDX_W-1:0] rsp_idx;
  logic             rsp_ine;

  modport master (
    output req_valid, req_op, req_inv_op, req_asid, req_vpn, rsp_ready,
    input  req_ready, rsp_valid, rsp_found, rsp_idx, rsp_ine
  );

  modport slave (
    input  req_valid, req_op, req_inv_op, req_asid, req_vpn, rsp_ready,
    output req_ready, rsp_valid, rsp_found, rsp_idx, rsp_ine
  );

endinterface

// File: rtl/tlb_rand_idx_gen.sv
// TLBFILL victim index source, advancing every cycle regardless of controller state.
// Define TLB_MAINT_LFSR_EN for a 16-bit LFSR; otherwise a wrapping counter is used.
module tlb_rand_idx_gen
  import tlb_maint_pkg::*;
#(
  parameter int unsigned TLB_ENTRY_NUM = 32,
  localparam int unsigned IDX_W = $clog2(TLB_ENTRY_NUM)
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [IDX_W-1:0] idx_o
);

`ifdef TLB_MAINT_LFSR_EN
  logic [15:0] lfsr_q, lfsr_d;

  // Fibonacci form, taps 16,14,13,11.
  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign idx_o = lfsr_q[IDX_W-1:0];
`else
  logic [IDX_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + IDX_W'(1);
    if (cnt_q == IDX_W'(TLB_ENTRY_NUM - 1)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign idx_o = cnt_q;
`endif

endmodule

// File: rtl/tlb_maint_ctrl.sv
// Sequences TLB maintenance ops into single-cycle MMU enables and returns one result per op.
// TLB_MAINT_LFSR_EN selects the LFSR victim-index source in tlb_rand_idx_gen.
module tlb_maint_ctrl
  import tlb_maint_pkg::*;
#(
  parameter int unsigned TLB_ENTRY_NUM = 32,
  parameter int unsigned SETTLE_CYCLES = 2,
  localparam int unsigned IDX_W = $clog2(TLB_ENTRY_NUM)
) (
  input  logic             clk,
  input  logic             rst_n,
  tlb_maint_ctrl_if.slave  bus,
  output logic             tlbsrch_en_o,
  output logic             tlbrd_en_o,
  output logic             tlbwr_en_o,
  output logic             tlbfill_en_o,
  output logic             invtlb_en_o,
  output logic [IDX_W-1:0] rand_idx_o,
  output logic [4:0]       invtlb_op_o,
  output logic [9:0]       invtlb_asid_o,
  output logic [18:0]      invtlb_vpn_o,
  input  logic             tlbsrch_found_i,
  input  logic [IDX_W-1:0] tlbsrch_idx_i,
  output logic             trans_block_o
);

  localparam logic [3:0] SettleInit = 4'(SETTLE_CYCLES);

  TlbMaintStateE    state_q, state_d;
  TlbMaintReqSt     req_q, req_d;
  TlbMaintRspSt     rsp_q, rsp_d;
  logic [IDX_W-1:0] rsp_idx_q, rsp_idx_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [4:0]       en_q, en_d;
  logic             block_q, block_d;

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    rsp_d     = rsp_q;
    rsp_idx_d = rsp_idx_q;
    cnt_d     = cnt_q;
    en_d      = '0;
    block_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          req_d.op     = TlbOpE'(bus.req_op);
          req_d.inv_op = bus.req_inv_op;
          req_d.asid   = bus.req_asid;
          req_d.vpn    = bus.req_vpn;
          rsp_d        = '0;
          rsp_idx_d    = '0;
          // Enables and blocking are registered from next-state, so decode the incoming op.
          en_d         = op_enable_mask(req_d);
          block_d      = op_blocks(req_d);
          state_d      = StIssue;
        end
      end
      StIssue: begin
        if (op_blocks(req_q)) begin
          cnt_d   = SettleInit;
          block_d = 1'b1;
          state_d = StSettle;
        end else if (req_q.op inside {TlbOpSrch, TlbOpRd}) begin
          state_d = StWait;
        end else begin
          // Illegal INVTLB (or undefined op): answer without touching the MMU.
          rsp_d.ine = (req_q.op == TlbOpInv);
          state_d   = StResp;
        end
      end
      StWait: begin
        if (req_q.op == TlbOpSrch) begin
          rsp_d.found = tlbsrch_found_i;
          rsp_idx_d   = tlbsrch_idx_i;
        end
        state_d = StResp;
      end
      StSettle: begin
        if (cnt_q == 4'd0) begin
          state_d = StResp;
        end else begin
          cnt_d   = cnt_q - 4'd1;
          // Translation resumes for the final settle cycle.
          block_d = (cnt_d != 4'd0);
        end
      end
      StResp: begin
        if (bus.rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    rsp_d.valid = (state_d == StResp);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      req_q     <= '0;
      rsp_q     <= '0;
      rsp_idx_q <= '0;
      cnt_q     <= '0;
      en_q      <= '0;
      block_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      rsp_q     <= rsp_d;
      rsp_idx_q <= rsp_idx_d;
      cnt_q     <= cnt_d;
      en_q      <= en_d;
      block_q   <= block_d;
    end
  end

  tlb_rand_idx_gen #(
    .TLB_ENTRY_NUM(TLB_ENTRY_NUM)
  ) u_rand_idx_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .idx_o(rand_idx_o)
  );

  assign bus.req_ready = (state_q == StIdle);
  assign bus.rsp_valid = rsp_q.valid;
  assign bus.rsp_found = rsp_q.found;
  assign bus.rsp_ine   = rsp_q.ine;
  assign bus.rsp_idx   = rsp_idx_q;

  assign tlbsrch_en_o  = en_q[EnSrch];
  assign tlbrd_en_o    = en_q[EnRd];
  assign tlbwr_en_o    = en_q[EnWr];
  assign tlbfill_en_o  = en_q[EnFill];
  assign invtlb_en_o   = en_q[EnInv];

  assign invtlb_op_o   = req_q.inv_op;
  assign invtlb_asid_o = req_q.asid;
  assign invtlb_vpn_o  = req_q.vpn;
  assign trans_block_o = block_q;

  en_onehot_a : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(en_q));

  rsp_hold_a : assert property (@(posedge clk) disable iff (!rst_n)
    (rsp_q.valid && !bus.rsp_ready) |=> (rsp_q.valid && $stable(rsp_q) && $stable(rsp_idx_q)));

endmodule

// File: tb/tb_tlb_maint_ctrl.sv
// Randomized scoreboard bench for tlb_maint_ctrl: driver pushes expected results,
// an independent monitor checks timing, enables and results against them.
`timescale 1ns/1ps
module tb_tlb_maint_ctrl;
  import tlb_maint_pkg::*;

  localparam int unsigned N  = 32;
  localparam int unsigned S  = 2;
  localparam int unsigned IW = $clog2(N);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tlb_maint_ctrl_if #(.TLB_ENTRY_NUM(N)) bus ();

  logic          srch_en, rd_en, wr_en, fill_en, inv_en, block;
  logic [IW-1:0] rand_idx;
  logic [4:0]    inv_op_o;
  logic [9:0]    asid_o;
  logic [18:0]   vpn_o;
  logic          found_i = 1'b0;
  logic [IW-1:0] idx_i = '0;
  logic [4:0]    en_all;
  assign en_all = {inv_en, fill_en, wr_en, rd_en, srch_en};

  tlb_maint_ctrl #(
    .TLB_ENTRY_NUM(N),
    .SETTLE_CYCLES(S)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .tlbsrch_en_o   (srch_en),
    .tlbrd_en_o     (rd_en),
    .tlbwr_en_o     (wr_en),
    .tlbfill_en_o   (fill_en),
    .invtlb_en_o    (inv_en),
    .rand_idx_o     (rand_idx),
    .invtlb_op_o    (inv_op_o),
    .invtlb_asid_o  (asid_o),
    .invtlb_vpn_o   (vpn_o),
    .tlbsrch_found_i(found_i),
    .tlbsrch_idx_i  (idx_i),
    .trans_block_o  (block)
  );

  typedef struct {
    int          op;
    logic        found;
    logic [IW-1:0] idx;
    logic        ine;
    logic [4:0]  en;
    int          lat;
    int          blk;
    logic [4:0]  inv_op;
    logic [9:0]  asid;
    logic [18:0] vpn;
  } exp_t;

  exp_t          sb_q[$];
  logic [IW:0]   mmu_q[$];
  int            vectors = 0;
  int            errors = 0;
  int            hold_cnt = 0;
  bit            mon_active = 1'b0;

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Reference model: result, enable, latency and blocking window of one op.
  function automatic exp_t model(int op, logic [4:0] iop, logic [9:0] asid, logic [18:0] vpn,
                                 logic f, logic [IW-1:0] ix);
    exp_t e;
    e.op = op; e.found = 1'b0; e.idx = '0; e.ine = 1'b0; e.en = '0; e.lat = 3; e.blk = 0;
    e.inv_op = iop; e.asid = asid; e.vpn = vpn;
    case (op)
      0: begin e.found = f; e.idx = ix; e.en = 5'b00001; end
      1: e.en = 5'b00010;
      2: begin e.en = 5'b00100; e.lat = 3 + S; e.blk = 1 + S; end
      3: begin e.en = 5'b01000; e.lat = 3 + S; e.blk = 1 + S; end
      default: begin
        if (iop > 5'd6) begin
          e.ine = 1'b1; e.lat = 2;
        end else begin
          e.en = 5'b10000; e.lat = 3 + S; e.blk = 1 + S;
        end
      end
    endcase
    return e;
  endfunction

  // Victim-index model, advanced on every clock edge outside reset.
`ifdef TLB_MAINT_LFSR_EN
  logic [15:0] lfsr_m = 16'hACE1;
  function automatic logic [IW-1:0] exp_rand();
    return lfsr_m[IW-1:0];
  endfunction
  initial begin : rand_model
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) lfsr_m = 16'hACE1;
      else lfsr_m = {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
    end
  end
`else
  int unsigned edge_cnt = 0;
  function automatic logic [IW-1:0] exp_rand();
    return IW'(edge_cnt % N);
  endfunction
  initial begin : rand_model
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) edge_cnt = 0;
      else edge_cnt++;
    end
  end
`endif

  // MMU model: answers a search the cycle after tlbsrch_en_o, noise otherwise.
  initial begin : mmu
    logic fire;
    logic [IW:0] ans;
    forever begin
      @(negedge clk);
      fire = srch_en;
      @(posedge clk);
      #1;
      if (fire && mmu_q.size() != 0) begin
        ans = mmu_q.pop_front();
        found_i = ans[IW];
        idx_i = ans[IW-1:0];
      end else begin
        found_i = 1'($urandom);
        idx_i = IW'($urandom);
      end
    end
  end

  initial begin : rsp_drv
    bus.rsp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (hold_cnt > 0) begin
        bus.rsp_ready = 1'b0;
        hold_cnt--;
      end else begin
        bus.rsp_ready = ($urandom_range(0, 3) != 0);
      end
    end
  end

  exp_t          e_cur;
  int            k, first_k, en_cnt, blk_cnt;
  bit            seen_rsp;
  logic [4:0]    en_or;
  logic          first_found, first_ine;
  logic [IW-1:0] first_idx, cap_rand, cap_rand_exp;
  logic [33:0]   cap_ops;

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mon_active = 1'b0;
        continue;
      end
      if (!mon_active) begin
        check("idle_req_ready", bus.req_ready, 1);
        check("idle_rsp_valid", bus.rsp_valid, 0);
        check("idle_trans_block", block, 0);
        check("idle_enables", en_all, 0);
        if (bus.req_valid && bus.req_ready) begin
          mon_active = 1'b1; k = 0; seen_rsp = 1'b0; en_or = '0; en_cnt = 0; blk_cnt = 0;
          cap_ops = '0; cap_rand = '0; cap_rand_exp = '0;
        end
        continue;
      end
      k++;
      check("busy_req_ready", bus.req_ready, 0);
      if (en_all != '0) begin
        en_or |= en_all;
        en_cnt++;
        if (inv_en) cap_ops = {inv_op_o, asid_o, vpn_o};
        if (fill_en) begin
          cap_rand = rand_idx;
          cap_rand_exp = exp_rand();
        end
      end
      if (block) blk_cnt++;
      if (seen_rsp) begin
        check("rsp_valid_held", bus.rsp_valid, 1);
        check("rsp_stable", {bus.rsp_found, bus.rsp_ine, bus.rsp_idx},
              {first_found, first_ine, first_idx});
      end else if (bus.rsp_valid) begin
        seen_rsp = 1'b1; first_k = k;
        first_found = bus.rsp_found; first_ine = bus.rsp_ine; first_idx = bus.rsp_idx;
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        mon_active = 1'b0;
        if (sb_q.size() == 0) begin
          check("sb_underflow", sb_q.size(), 1);
        end else begin
          e_cur = sb_q.pop_front();
          check("latency", first_k, e_cur.lat);
          check("rsp_found", bus.rsp_found, e_cur.found);
          check("rsp_idx", bus.rsp_idx, e_cur.idx);
          check("rsp_ine", bus.rsp_ine, e_cur.ine);
          check("enable_mask", en_or, e_cur.en);
          check("enable_pulses", en_cnt, (e_cur.en != '0) ? 1 : 0);
          check("block_cycles", blk_cnt, e_cur.blk);
          check("invtlb_regs", {inv_op_o, asid_o, vpn_o},
                {e_cur.inv_op, e_cur.asid, e_cur.vpn});
          check("rand_idx", rand_idx, exp_rand());
          if (e_cur.op == 4 && e_cur.en != '0)
            check("inv_pulse_operands", cap_ops, {e_cur.inv_op, e_cur.asid, e_cur.vpn});
          if (e_cur.op == 3) check("fill_rand_idx", cap_rand, cap_rand_exp);
        end
      end else if (k > 400) begin
        check("rsp_timeout", bus.rsp_valid, 1);
        mon_active = 1'b0;
      end
    end
  end

  task automatic send(input int op, input logic [4:0] iop, input logic [9:0] asid,
                      input logic [18:0] vpn, input logic f, input logic [IW-1:0] ix);
    int t;
    bus.req_valid = 1'b1;
    bus.req_op = 3'(op);
    bus.req_inv_op = iop;
    bus.req_asid = asid;
    bus.req_vpn = vpn;
    t = 0;
    forever begin
      @(negedge clk);
      if (rst_n && bus.req_ready) break;
      t++;
      if (t > 400) break;
    end
    if (t > 400) begin
      check("req_ready_timeout", bus.req_ready, 1);
    end else begin
      sb_q.push_back(model(op, iop, asid, vpn, f, ix));
      if (op == 0) mmu_q.push_back({f, ix});
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_op = 3'($urandom);
    bus.req_inv_op = 5'($urandom);
    bus.req_asid = 10'($urandom);
    bus.req_vpn = 19'($urandom);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_req_ready"}, bus.req_ready, 1);
    check({tag, "_rsp"}, {bus.rsp_valid, bus.rsp_found, bus.rsp_ine, bus.rsp_idx}, 0);
    check({tag, "_enables"}, en_all, 0);
    check({tag, "_trans_block"}, block, 0);
    check({tag, "_invtlb"}, {inv_op_o, asid_o, vpn_o}, 0);
    check({tag, "_rand_idx"}, rand_idx, exp_rand());
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: run did not complete, expected finish before %0t", $time);
    $fatal(1);
  end

  initial begin : main
    int op, t;
    logic [4:0] iop;
    bus.req_valid = 1'b0;
    bus.req_op = '0;
    bus.req_inv_op = '0;
    bus.req_asid = '0;
    bus.req_vpn = '0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    send(0, 5'd0, 10'd0, 19'd0, 1'b1, IW'(5));           // search hit at index 5
    send(3, 5'd0, 10'h15, 19'h2, 1'b0, '0);              // fill
    send(4, 5'd7, 10'h1, 19'h1, 1'b0, '0);               // illegal invtlb
    send(4, 5'd5, 10'h3, 19'h1234, 1'b0, '0);            // legal invtlb operands
    send(2, 5'd0, 10'h0, 19'h0, 1'b0, '0);               // write with response backpressure
    hold_cnt = 15;
    send(1, 5'd0, 10'h0, 19'h0, 1'b0, '0);               // waits behind the write

    // Asynchronous reset while the write is settling.
    send(2, 5'd0, 10'h2aa, 19'h5555, 1'b0, '0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("midop_reset");
    sb_q.delete();
    mmu_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 150; i++) begin
      op = $urandom_range(0, 4);
      if ($urandom_range(0, 3) == 0) iop = 5'($urandom);
      else iop = 5'($urandom_range(0, 6));
      send(op, iop, 10'($urandom), 19'($urandom), 1'($urandom), IW'($urandom));
      if ($urandom_range(0, 4) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
    end

    t = 0;
    while ((mon_active || sb_q.size() != 0) && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 1000) check("drain_pending", sb_q.size(), 0);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
